// File: rtl/cell_selftest_ctrl.sv
// Self-test sequencer for the primitive cell library: drives every input vector through each cell and
// checks the result against a golden model. Define FAULT_INJECT_EN to add inject_en/inject_cell ports.

module cst_buf_cell (
  input  logic a,
  output logic y
);
  assign y = a;
endmodule

module cst_and_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module cst_or_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module cst_xor_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module cst_nand_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module cst_not_cell (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module cst_mux_cell (
  input  logic sel,
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = sel ? a : b;
endmodule

module cst_dff_cell (
  input  logic clk,
  input  logic d,
  output logic q,
  output logic qn
);
  logic q_q;

  always_ff @(posedge clk) begin
    q_q <= d;
  end

  assign q  = q_q;
  assign qn = ~q_q;
endmodule

module cell_selftest_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef FAULT_INJECT_EN
  input  logic       inject_en,
  input  logic [2:0] inject_cell,
`endif
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask,
  output logic [6:0] err_count,
  output logic [2:0] cur_cell
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("cell_selftest_ctrl: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] cell_q, cell_d;
  logic [2:0] vec_q, vec_d;
  logic [2:0] stim_q, stim_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] fail_q, fail_d;
  logic [6:0] err_q, err_d;
  logic       pass_q, pass_d;

  logic stim_a, stim_b, stim_sel;
  assign stim_a   = stim_q[0];
  assign stim_b   = stim_q[1];
  assign stim_sel = stim_q[2];

  logic y_buf, y_and, y_or, y_xor, y_nand, y_not, y_mux, dff_q, dff_qn;

  cst_buf_cell  u_buf  (.a(stim_a), .y(y_buf));
  cst_and_cell  u_and  (.a(stim_a), .b(stim_b), .y(y_and));
  cst_or_cell   u_or   (.a(stim_a), .b(stim_b), .y(y_or));
  cst_xor_cell  u_xor  (.a(stim_a), .b(stim_b), .y(y_xor));
  cst_nand_cell u_nand (.a(stim_a), .b(stim_b), .y(y_nand));
  cst_not_cell  u_not  (.a(stim_a), .y(y_not));
  cst_mux_cell  u_mux  (.sel(stim_sel), .a(stim_a), .b(stim_b), .y(y_mux));
  cst_dff_cell  u_dff  (.clk(clk), .d(stim_a), .q(dff_q), .qn(dff_qn));

  // Observed outputs packed by cell index, {obs1,obs0} per cell.
  logic [7:0][1:0] obs_all;
  assign obs_all = {{dff_qn, dff_q}, {1'b0, y_mux}, {1'b0, y_not}, {1'b0, y_nand},
                    {1'b0, y_xor}, {1'b0, y_or}, {1'b0, y_and}, {1'b0, y_buf}};

  logic [1:0] inj_flip;
`ifdef FAULT_INJECT_EN
  assign inj_flip = {2{inject_en && (inject_cell == cell_q)}};
`else
  assign inj_flip = 2'b00;
`endif

  logic [1:0] obs_cur;
  logic [1:0] gold;
  logic       mismatch;

  assign obs_cur = obs_all[cell_q] ^ inj_flip;

  always_comb begin
    gold = 2'b00;
    case (cell_q)
      3'd0: gold = {1'b0, stim_a};
      3'd1: gold = {1'b0, stim_a & stim_b};
      3'd2: gold = {1'b0, stim_a | stim_b};
      3'd3: gold = {1'b0, stim_a ^ stim_b};
      3'd4: gold = {1'b0, ~(stim_a & stim_b)};
      3'd5: gold = {1'b0, ~stim_a};
      3'd6: gold = {1'b0, stim_sel ? stim_a : stim_b};
      default: gold = {~stim_a, stim_a};
    endcase
  end

  assign mismatch = (obs_cur != gold);

  always_comb begin
    state_d  = state_q;
    cell_d   = cell_q;
    vec_d    = vec_q;
    stim_d   = stim_q;
    settle_d = settle_q;
    fail_d   = fail_q;
    err_d    = err_q;
    pass_d   = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_APPLY;
          fail_d  = 8'h00;
          err_d   = 7'd0;
          pass_d  = 1'b0;
          cell_d  = 3'd0;
          vec_d   = 3'd0;
        end
      end
      S_APPLY: begin
        stim_d   = vec_q;
        settle_d = SETTLE_LOAD;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          fail_d[cell_q] = 1'b1;
          err_d          = err_q + 7'd1;
        end
        vec_d = vec_q + 3'd1;
        if (vec_q == 3'd7) begin
          cell_d = cell_q + 3'd1;
        end
        // pass reflects the final vector's result as well, so use the updated mask.
        if (cell_q == 3'd7 && vec_q == 3'd7) begin
          state_d = S_DONE;
          pass_d  = (fail_d == 8'h00);
        end else begin
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cell_q   <= 3'd0;
      vec_q    <= 3'd0;
      stim_q   <= 3'd0;
      settle_q <= 4'd0;
      fail_q   <= 8'h00;
      err_q    <= 7'd0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cell_q   <= cell_d;
      vec_q    <= vec_d;
      stim_q   <= stim_d;
      settle_q <= settle_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
    end
  end

  assign busy      = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign fail_mask = fail_q;
  assign err_count = err_q;
  assign cur_cell  = cell_q;

endmodule

// File: tb/tb_cell_selftest_ctrl.sv
// Directed bench for cell_selftest_ctrl: run timing, ignored starts, mid-run reset, optional fault injection.
module tb_cell_selftest_ctrl;

  logic clk;
  logic reset;
  logic start;
  logic start3;
  logic use3;

  logic       busy1, done1, pass1;
  logic [7:0] mask1;
  logic [6:0] err1;
  logic [2:0] cell1;
  logic       busy3, done3, pass3;
  logic [7:0] mask3;
  logic [6:0] err3;
  logic [2:0] cell3;

`ifdef FAULT_INJECT_EN
  logic       inject_en;
  logic [2:0] inject_cell;
  logic       inject_en3;
  logic [2:0] inject_cell3;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         done_cyc;
    logic       pass;
    logic [7:0] mask;
    logic [6:0] err;
  } sb_t;

  sb_t sb[$];

  cell_selftest_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef FAULT_INJECT_EN
    .inject_en(inject_en), .inject_cell(inject_cell),
`endif
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(mask1), .err_count(err1), .cur_cell(cell1)
  );

  cell_selftest_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3),
`ifdef FAULT_INJECT_EN
    .inject_en(inject_en3), .inject_cell(inject_cell3),
`endif
    .busy(busy3), .done(done3), .pass(pass3),
    .fail_mask(mask3), .err_count(err3), .cur_cell(cell3)
  );

  logic       o_busy, o_done, o_pass;
  logic [7:0] o_mask;
  logic [6:0] o_err;
  logic [2:0] o_cell;
  assign o_busy = use3 ? busy3 : busy1;
  assign o_done = use3 ? done3 : done1;
  assign o_pass = use3 ? pass3 : pass1;
  assign o_mask = use3 ? mask3 : mask1;
  assign o_err  = use3 ? err3  : err1;
  assign o_cell = use3 ? cell3 : cell1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (use3) start3 = v;
    else start = v;
  endtask

  // One run: start in cycle 0, optional ignored re-pulses, optional reset abort at rst_at.
  task automatic run(input int settle, input int pa, input int pb, input int rst_at,
                     input logic inj_en, input logic [2:0] inj_cell);
    int  per_cell;
    int  done_cyc;
    int  last;
    sb_t it;
    sb_t got;
    per_cell    = 8 * (settle + 2);
    done_cyc    = 64 * (settle + 2) + 1;
    last        = done_cyc + 8;
    it.done_cyc = done_cyc;
    it.mask     = inj_en ? (8'h01 << inj_cell) : 8'h00;
    it.err      = inj_en ? 7'd8 : 7'd0;
    it.pass     = !inj_en;
    if (rst_at == 0) sb.push_back(it);
    drive_start(1'b1);
    step();
    for (int cyc = 1; cyc <= last; cyc++) begin
      drive_start((cyc == pa) || (cyc == pb));
      chk($sformatf("busy@%0d", cyc), 32'(o_busy), 32'(cyc < done_cyc));
      chk($sformatf("done@%0d", cyc), 32'(o_done), 32'(cyc == done_cyc));
      if (((cyc - 1) % per_cell) == 0 && cyc < done_cyc)
        chk($sformatf("cur_cell@%0d", cyc), 32'(o_cell), 32'((cyc - 1) / per_cell));
      if (o_done) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(got.done_cyc));
          chk("pass", 32'(o_pass), 32'(got.pass));
          chk("fail_mask", 32'(o_mask), 32'(got.mask));
          chk("err_count", 32'(o_err), 32'(got.err));
          $display("run settle=%0d inj=%0b/%0d done@%0d pass=%0b mask=%02h err=%0d",
                   settle, inj_en, inj_cell, cyc, o_pass, o_mask, o_err);
        end
      end
      if (cyc == rst_at) begin
        drive_start(1'b0);
        reset = 1'b1;
        step();
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_pass", 32'(o_pass), 32'd0);
        chk("rst_mask", 32'(o_mask), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_cell", 32'(o_cell), 32'd0);
        $display("reset abort at cycle %0d, outputs cleared", cyc);
        reset = 1'b0;
        step();
        return;
      end
      if (cyc == last) chk("pass_held", 32'(o_pass), 32'(it.pass));
      step();
    end
    drive_start(1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    start3 = 1'b0;
    use3   = 1'b0;
`ifdef FAULT_INJECT_EN
    inject_en    = 1'b0;
    inject_cell  = 3'd0;
    inject_en3   = 1'b0;
    inject_cell3 = 3'd0;
`endif
    step();
    step();
    chk("init_busy", 32'(busy1), 32'd0);
    chk("init_done", 32'(done1), 32'd0);
    chk("init_pass", 32'(pass1), 32'd0);
    chk("init_mask", 32'(mask1), 32'd0);
    chk("init_err", 32'(err1), 32'd0);
    chk("init_cell", 32'(cell1), 32'd0);
    reset = 1'b0;
    step();

    run(1, -1, -1, 0, 1'b0, 3'd0);
    run(1, 50, 193, 0, 1'b0, 3'd0);
    run(1, -1, -1, 100, 1'b0, 3'd0);
    run(1, -1, -1, 0, 1'b0, 3'd0);

`ifdef FAULT_INJECT_EN
    inject_en   = 1'b1;
    inject_cell = 3'd2;
    run(1, -1, -1, 0, 1'b1, 3'd2);
    inject_cell = 3'd7;
    run(1, -1, -1, 0, 1'b1, 3'd7);
    inject_en = 1'b0;
    run(1, -1, -1, 0, 1'b0, 3'd0);
`endif

    use3 = 1'b1;
    run(3, -1, -1, 0, 1'b0, 3'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
